// File: rtl/gmii_frame_gen.sv
// ---------------------------------------------------------------------------
// gmii_frame_gen
//   GMII Ethernet traffic generator. Each frame is built as:
//     [preamble 7x55 + D5] dst MAC, src MAC, [8100 + TCI], type,
//     patterned payload, [CRC-32 FCS], then inter-frame idle.
//   A run sends cfg_num_frames frames, or runs continuously (num = 0) until
//   cfg_stop. Payload length can sweep between a clamped min and max.
//
// Ports
//   gmii_gtxc      in   125 MHz TX clock, all logic on the rising edge
//   reset_n        in   synchronous active-low reset
//   cfg_start      in   start pulse, only looked at in IDLE
//   cfg_stop       in   live stop request; the current frame still finishes
//   cfg_num_frames in   frames per run, 0 = continuous
//   cfg_dst_mac    in   destination MAC
//   cfg_src_mac    in   source MAC
//   cfg_eth_type   in   type/length field
//   cfg_len_min    in   first / minimum payload length
//   cfg_len_max    in   maximum payload length for the sweep
//   cfg_ifg        in   requested idle cycles between frames
//   cfg_mode       in   payload pattern (0/3 incr, 1 fill, 2 seq + incr)
//   cfg_fill       in   fill byte for mode 1
//   gmii_txd       out  TX data (registered)
//   gmii_txen      out  TX enable (registered)
//   gmii_txer      out  TX error, tied low
//   busy           out  high from accepted start until the run is done
//   done           out  level, set at end of run, cleared by next start
//   frame_cnt      out  frames completed in this run
//   fsm_state      out  current FSM state, for debug and checkers
//
// Handshake: there is no backpressure. cfg_start is a one-cycle request that
// is accepted only when fsm_state is IDLE; it is dropped in any other state.
// ---------------------------------------------------------------------------
module gmii_frame_gen #(
  parameter bit          PREAMBLE_EN = 1'b1,
  parameter bit          CRC_EN      = 1'b1,
  parameter bit          VLAN_EN     = 1'b0,
  parameter logic [15:0] VLAN_TCI    = 16'h0001,
  parameter int          IFG_MIN     = 12,
  parameter int          LEN_MIN     = 46,
  parameter int          LEN_MAX     = 1500
) (
  input  logic        gmii_gtxc,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [15:0] cfg_num_frames,
  input  logic [47:0] cfg_dst_mac,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_eth_type,
  input  logic [10:0] cfg_len_min,
  input  logic [10:0] cfg_len_max,
  input  logic [7:0]  cfg_ifg,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_fill,
  output logic [7:0]  gmii_txd,
  output logic        gmii_txen,
  output logic        gmii_txer,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam int HDR_LEN = VLAN_EN ? 18 : 14;

  // The register for every state reflects the byte currently on gmii_txd:
  // next-state logic picks the coming byte and it is registered together
  // with the state, so the first byte is on the wire right after the edge
  // that accepts cfg_start.
  state_t      state, nxt_state;
  logic [10:0] cnt, nxt_cnt;

  logic [15:0] num_q;
  logic [47:0] dst_q, src_q;
  logic [15:0] type_q;
  logic [10:0] lmin_q, lmax_q, cur_len, next_len;
  logic [7:0]  ifg_q, ifg_eff;
  logic [1:0]  mode_q;
  logic [7:0]  fill_q;
  logic        stop_q;
  logic [31:0] crc_q, crc_d, crc_base;

  logic        start_ok, run_end, frame_last, ifg_enter;
  logic [7:0]  nxt_byte;
  logic        nxt_en;

  logic [47:0]  dst_sel, src_sel;
  logic [15:0]  type_sel;
  logic [143:0] hdr_vec;
  int           hidx;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    logic [10:0] r;
    r = len;
    if (r < 11'(LEN_MIN)) r = 11'(LEN_MIN);
    if (r > 11'(LEN_MAX)) r = 11'(LEN_MAX);
    return r;
  endfunction

  // One byte of reflected CRC-32 (poly 0xEDB88320), LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign gmii_txer = 1'b0;
  assign fsm_state = state;

  assign start_ok = (state == S_IDLE) && cfg_start;
  assign run_end  = stop_q || ((num_q != 16'd0) && (frame_cnt == num_q));

  // Zero would make the IFG counter wrap; one idle cycle is the floor.
  always_comb begin
    ifg_eff = (cfg_ifg < 8'(IFG_MIN)) ? 8'(IFG_MIN) : cfg_ifg;
    if (ifg_eff == 8'd0) ifg_eff = 8'd1;
  end

  // Next state / byte counter
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          nxt_state = PREAMBLE_EN ? S_PRE : S_HDR;
          nxt_cnt   = 11'd0;
        end
      end
      S_PRE: begin
        if (cnt == 11'd7) begin
          nxt_state = S_HDR;
          nxt_cnt   = 11'd0;
        end else begin
          nxt_cnt = cnt + 11'd1;
        end
      end
      S_HDR: begin
        if (cnt == 11'(HDR_LEN - 1)) begin
          nxt_state = S_PAY;
          nxt_cnt   = 11'd0;
        end else begin
          nxt_cnt = cnt + 11'd1;
        end
      end
      S_PAY: begin
        if (cnt == cur_len - 11'd1) begin
          nxt_state = CRC_EN ? S_FCS : S_IFG;
          nxt_cnt   = 11'd0;
        end else begin
          nxt_cnt = cnt + 11'd1;
        end
      end
      S_FCS: begin
        if (cnt == 11'd3) begin
          nxt_state = S_IFG;
          nxt_cnt   = 11'd0;
        end else begin
          nxt_cnt = cnt + 11'd1;
        end
      end
      S_IFG: begin
        if (cnt == {3'b000, ifg_q} - 11'd1) begin
          nxt_state = run_end ? S_DONE : (PREAMBLE_EN ? S_PRE : S_HDR);
          nxt_cnt   = 11'd0;
        end else begin
          nxt_cnt = cnt + 11'd1;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_cnt   = 11'd0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = 11'd0;
      end
    endcase
  end

  // Header fields: on the accepting edge the latched copies are not loaded
  // yet, so a frame without preamble takes its first byte from the inputs.
  always_comb begin
    dst_sel  = (state == S_IDLE) ? cfg_dst_mac  : dst_q;
    src_sel  = (state == S_IDLE) ? cfg_src_mac  : src_q;
    type_sel = (state == S_IDLE) ? cfg_eth_type : type_q;
    hdr_vec  = VLAN_EN ? {dst_sel, src_sel, 16'h8100, VLAN_TCI, type_sel}
                       : {dst_sel, src_sel, type_sel, 32'h0000_0000};
    hidx = 17 - int'(nxt_cnt[4:0]);
    if (hidx < 0) hidx = 0;
  end

  // Byte that goes on the wire after the coming edge
  always_comb begin
    nxt_byte = 8'h00;
    nxt_en   = 1'b0;
    case (nxt_state)
      S_PRE: begin
        nxt_en   = 1'b1;
        nxt_byte = (nxt_cnt == 11'd7) ? 8'hD5 : 8'h55;
      end
      S_HDR: begin
        nxt_en   = 1'b1;
        nxt_byte = hdr_vec[hidx*8 +: 8];
      end
      S_PAY: begin
        nxt_en = 1'b1;
        if (mode_q == 2'd1) begin
          nxt_byte = fill_q;
        end else if ((mode_q == 2'd2) && (nxt_cnt == 11'd0)) begin
          nxt_byte = frame_cnt[15:8];
        end else if ((mode_q == 2'd2) && (nxt_cnt == 11'd1)) begin
          nxt_byte = frame_cnt[7:0];
        end else begin
          nxt_byte = nxt_cnt[7:0] + 8'd1;
        end
      end
      S_FCS: begin
        nxt_en = 1'b1;
        case (nxt_cnt[1:0])
          2'd0:    nxt_byte = ~crc_q[7:0];
          2'd1:    nxt_byte = ~crc_q[15:8];
          2'd2:    nxt_byte = ~crc_q[23:16];
          default: nxt_byte = ~crc_q[31:24];
        endcase
      end
      default: begin
        nxt_byte = 8'h00;
        nxt_en   = 1'b0;
      end
    endcase
  end

  // CRC tracks the bytes as they are registered; it restarts on dst byte 0
  // and is frozen through the FCS bytes.
  always_comb begin
    crc_base = ((nxt_state == S_HDR) && (nxt_cnt == 11'd0)) ? 32'hFFFF_FFFF : crc_q;
    crc_d    = crc_q;
    if ((nxt_state == S_HDR) || (nxt_state == S_PAY)) begin
      crc_d = crc_byte(crc_base, nxt_byte);
    end
  end

  assign frame_last = CRC_EN ? ((nxt_state == S_FCS) && (nxt_cnt == 11'd3))
                             : ((nxt_state == S_PAY) && (nxt_cnt == cur_len - 11'd1));
  // Length advances once the frame is off the wire, so the PAY compare
  // never sees it change mid-frame.
  assign ifg_enter  = (nxt_state == S_IFG) && (state != S_IFG);
  assign next_len   = ((lmin_q >= lmax_q) || (cur_len >= lmax_q)) ? lmin_q
                                                                  : cur_len + 11'd1;

  always_ff @(posedge gmii_gtxc) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 11'd0;
      gmii_txd  <= 8'h00;
      gmii_txen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 16'd0;
      crc_q     <= 32'hFFFF_FFFF;
      num_q     <= 16'd0;
      dst_q     <= 48'd0;
      src_q     <= 48'd0;
      type_q    <= 16'd0;
      lmin_q    <= 11'd0;
      lmax_q    <= 11'd0;
      cur_len   <= 11'd0;
      ifg_q     <= 8'd0;
      mode_q    <= 2'd0;
      fill_q    <= 8'd0;
      stop_q    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      gmii_txd  <= nxt_byte;
      gmii_txen <= nxt_en;
      crc_q     <= crc_d;
      if (start_ok) begin
        num_q     <= cfg_num_frames;
        dst_q     <= cfg_dst_mac;
        src_q     <= cfg_src_mac;
        type_q    <= cfg_eth_type;
        lmin_q    <= clamp_len(cfg_len_min);
        lmax_q    <= clamp_len(cfg_len_max);
        cur_len   <= clamp_len(cfg_len_min);
        ifg_q     <= ifg_eff;
        mode_q    <= cfg_mode;
        fill_q    <= cfg_fill;
        stop_q    <= 1'b0;
        frame_cnt <= 16'd0;
        busy      <= 1'b1;
        done      <= 1'b0;
      end else begin
        if (cfg_stop && (state != S_IDLE) && (state != S_DONE)) stop_q <= 1'b1;
        if (frame_last) frame_cnt <= frame_cnt + 16'd1;
        if (ifg_enter) cur_len <= next_len;
        if (nxt_state == S_DONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
